interrupt_scheduler: RTL

//  Sequences context switches for the single-cycle MIPS core.
//  - Owns the preemption timer and latches interrupt sources: halt, timer, keyboard.
//  - Arbitrates the sources by fixed priority.
//  - Redirects the PC to the kernel vector and saves the interrupted PC and cause code.
//  - Masks further interrupts until the kernel acknowledges with GetInterruption.
//  - Sits beside the PC: ForcePC muxes VectorPC into the PC input; SavedPC and Cause feed the register-file write mux.

---
 rtl/interrupt_scheduler_if.sv | 28 ++
 rtl/interrupt_scheduler.sv | 117 +++++++++++
 2 files changed

// File: rtl/interrupt_scheduler_if.sv
// Core <-> interrupt scheduler signal bundle: sources and PC in, redirect, saved PC and cause out.
interface interrupt_scheduler_if #(
  parameter int PC_WIDTH    = 11,
  parameter int TIMER_WIDTH = 16,
  parameter int CAUSE_WIDTH = 32
);
  logic                   Halt;
  logic                   SetTimer;
  logic [TIMER_WIDTH-1:0] TimerValue;
  logic                   KeyIrq;
  logic [PC_WIDTH-1:0]    NextPC;
  logic                   GetInterruption;
  logic                   ForcePC;
  logic [PC_WIDTH-1:0]    VectorPC;
  logic [PC_WIDTH-1:0]    SavedPC;
  logic [CAUSE_WIDTH-1:0] Cause;
  logic                   InHandler;

  modport master (
    output Halt, SetTimer, TimerValue, KeyIrq, NextPC, GetInterruption,
    input  ForcePC, VectorPC, SavedPC, Cause, InHandler
  );

  modport slave (
    input  Halt, SetTimer, TimerValue, KeyIrq, NextPC, GetInterruption,
    output ForcePC, VectorPC, SavedPC, Cause, InHandler
  );
endinterface

// File: rtl/interrupt_scheduler.sv
// Preemption timer, fixed-priority interrupt take and kernel masking for the single-cycle core.
// Optional keyboard source enabled by defining INT_SCHED_KEYBOARD_EN.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  ST_USER   | user code; timer counts, any pending source is taken
//  ST_KERNEL | handler running; timer frozen, sources latch until the ack
module interrupt_scheduler #(
  parameter int          PC_WIDTH    = 11,
  parameter int          TIMER_WIDTH = 16,
  parameter int unsigned VECTOR_ADDR = 0,
  parameter int          CAUSE_WIDTH = 32
) (
  input logic                  Clock,
  input logic                  Reset_n,
  interrupt_scheduler_if.slave irq
);

  typedef enum logic {ST_USER, ST_KERNEL} state_t;

  localparam int P_TMR  = 0;
  localparam int P_HALT = 1;
  localparam int P_KEY  = 2;

  state_t                 state, state_next;
  logic [2:0]             pending;
  logic [2:0]             pend_set, pend_clr, win;
  logic [1:0]             take_code;
  logic                   force_pc;
  logic [TIMER_WIDTH-1:0] counter, quantum;
  logic                   armed, expire, disarm, key_set;

`ifdef INT_SCHED_KEYBOARD_EN
  assign key_set = irq.KeyIrq;
`else
  logic unused_key_irq;
  assign unused_key_irq = irq.KeyIrq;
  assign key_set        = 1'b0;
`endif

  assign armed  = (quantum != '0);
  assign expire = !irq.SetTimer && (state == ST_USER) && armed
                  && (counter == TIMER_WIDTH'(1));
  assign disarm = irq.SetTimer && (irq.TimerValue == '0);

  always_ff @(posedge Clock) begin
    if (!Reset_n) state <= ST_USER;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    force_pc   = 1'b0;
    win        = 3'b000;
    take_code  = 2'd0;
    case (state)
      ST_USER: begin
        if (|pending) begin
          force_pc   = 1'b1;
          state_next = ST_KERNEL;
          if (pending[P_HALT]) begin
            win[P_HALT] = 1'b1;
            take_code   = 2'd2;
          end else if (pending[P_TMR]) begin
            win[P_TMR] = 1'b1;
            take_code  = 2'd1;
          end else begin
            win[P_KEY] = 1'b1;
            take_code  = 2'd3;
          end
        end
      end
      ST_KERNEL: begin
        if (irq.GetInterruption) state_next = ST_USER;
      end
      default: state_next = ST_USER;
    endcase
  end

  // A set in the same cycle beats the take or disarm clear of that bit.
  assign pend_set = {key_set, irq.Halt, expire};
  assign pend_clr = win | {2'b00, disarm};

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      pending       <= '0;
      counter       <= '0;
      quantum       <= '0;
      irq.SavedPC   <= '0;
      irq.Cause     <= '0;
      irq.InHandler <= 1'b0;
    end else begin
      pending <= (pending & ~pend_clr) | pend_set;

      if (irq.SetTimer) begin
        quantum <= irq.TimerValue;
        counter <= irq.TimerValue;
      end else if ((state == ST_USER) && armed) begin
        if (counter == TIMER_WIDTH'(1)) counter <= quantum;
        else if (counter != '0)         counter <= counter - TIMER_WIDTH'(1);
      end

      if (force_pc) begin
        irq.SavedPC   <= irq.NextPC;
        irq.Cause     <= CAUSE_WIDTH'(take_code);
        irq.InHandler <= 1'b1;
      end else if ((state == ST_KERNEL) && irq.GetInterruption) begin
        irq.Cause     <= '0;
        irq.InHandler <= 1'b0;
      end
    end
  end

  assign irq.ForcePC  = force_pc;
  assign irq.VectorPC = PC_WIDTH'(VECTOR_ADDR);

endmodule
